// File: rtl/sw_debouncer_pkg.sv
// Shared constants and types for the switch debouncer.
// Board and simulation debounce depths live here.
package sw_debouncer_pkg;

  localparam int N_SW_DEF = 8;
  localparam int DEBOUNCE_CYCLES_BOARD = 500000;
  localparam int DEBOUNCE_CYCLES_SIM = 4;

  typedef enum logic {
    ST_STABLE,
    ST_PENDING
  } db_state_e;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, clean output.
// SW_DEBOUNCER_BYPASS_EN drops the counter and forwards s2 directly.
module sw_debounce_bit
  import sw_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic sw_o,
  output logic accepted_o
);

  logic s1_q;
  logic s2_q;
  logic sw_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sw_i;
      s2_q <= s1_q;
    end
  end

  assign sw_o = sw_q;

`ifdef SW_DEBOUNCER_BYPASS_EN

  assign accepted_o = s2_q ^ sw_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sw_q <= 1'b0;
    end else begin
      sw_q <= s2_q;
    end
  end

`else

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_e state;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic sw_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sw_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sw_q  <= sw_d;
    end
  end

  // State is implied by whether the synchronised level disagrees with sw_q.
  always_comb begin
    cnt_d      = cnt_q;
    sw_d       = sw_q;
    accepted_o = 1'b0;
    state      = (s2_q != sw_q) ? ST_PENDING : ST_STABLE;
    unique case (state)
      ST_STABLE: begin
        cnt_d = '0;
      end
      ST_PENDING: begin
        if (cnt_q == LAST) begin
          sw_d       = s2_q;
          cnt_d      = '0;
          accepted_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

`endif

endmodule

// File: rtl/sw_debouncer.sv
// N_SW-bit switch debouncer with a one-cycle changed_o strobe.
// Define SW_DEBOUNCER_BYPASS_EN for a counter-free fast-sim build.
module sw_debouncer
  import sw_debouncer_pkg::*;
#(
  parameter int N_SW = N_SW_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_SW-1:0] sw_i,
  output logic [N_SW-1:0] sw_o,
  output logic            changed_o
);

  logic [N_SW-1:0] accepted;

  for (genvar g = 0; g < N_SW; g++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_bit (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .sw_i(sw_i[g]),
      .sw_o(sw_o[g]),
      .accepted_o(accepted[g])
    );
  end

  // Registered alongside sw_o so the pulse lines up with the new word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      changed_o <= 1'b0;
    end else begin
      changed_o <= |accepted;
    end
  end

endmodule

// File: tb/tb_sw_debouncer.sv
// Self-checking bench for sw_debouncer with DEBOUNCE_CYCLES = 4.
// Reference model: output flips once the last D synchronised samples all differ.
module tb_sw_debouncer;
  import sw_debouncer_pkg::*;

  localparam int N = N_SW_DEF;
  localparam int D = DEBOUNCE_CYCLES_SIM;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [N-1:0] sw_i  = '0;
  logic [N-1:0] sw_o;
  logic         changed_o;

  int n_cmp = 0;
  int n_bad = 0;

  sw_debouncer #(
    .N_SW(N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .sw_i(sw_i),
    .sw_o(sw_o),
    .changed_o(changed_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: raw samples delayed two edges, then a window of synchronised samples.
  logic [N-1:0] raw_q[$];
  logic [N-1:0] win_q[$];
  logic [N-1:0] m_sw;
  logic         m_chg;

  task automatic model_reset();
    raw_q = {};
    raw_q.push_back('0);
    raw_q.push_back('0);
    win_q = {};
    m_sw  = '0;
    m_chg = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] v);
    logic [N-1:0] s2;
    logic [N-1:0] nxt;
    bit all_diff;
    s2 = raw_q.pop_front();
    raw_q.push_back(v);
    win_q.push_back(s2);
    if (win_q.size() > D) void'(win_q.pop_front());
    nxt = m_sw;
`ifdef SW_DEBOUNCER_BYPASS_EN
    nxt = s2;
`else
    if (win_q.size() == D) begin
      for (int b = 0; b < N; b++) begin
        all_diff = 1'b1;
        foreach (win_q[i]) if (win_q[i][b] == m_sw[b]) all_diff = 1'b0;
        if (all_diff) nxt[b] = s2[b];
      end
    end
`endif
    m_chg = (nxt != m_sw);
    m_sw  = nxt;
  endtask

  task automatic chk(input string nm, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive, clock, then compare against the model just after the edge.
  task automatic step(input logic [N-1:0] v, input logic r);
    rst_i = r;
    sw_i  = v;
    @(posedge clk_i);
    if (r) model_reset();
    else model_edge(v);
    #1;
    chk("sw_o", sw_o, m_sw);
    chk("changed_o", {7'b0, changed_o}, {7'b0, m_chg});
  endtask

  typedef struct {
    logic [N-1:0] sw;
    logic [N-1:0] exp_sw;
    logic         exp_chg;
  } vec_t;

  vec_t tbl[7];
  int   pulses;
  logic [N-1:0] cur;

  initial begin
    model_reset();

    // Reset held with all switches high: outputs stay clear.
    for (int i = 0; i < 10; i++) begin
      step(8'hFF, 1'b1);
      chk("rst_sw_o", sw_o, 8'h00);
      chk("rst_changed", {7'b0, changed_o}, 8'h00);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(8'hFF, 1'b0);
      if (changed_o) pulses++;
    end
    chk("rst_release_word", sw_o, 8'hFF);
    chk("rst_release_pulses", 8'(pulses), 8'd1);

    // Return to zero and settle.
    for (int i = 0; i < 8; i++) step(8'h00, 1'b0);

    // Step to A5 and hold: constant expectations per edge.
`ifdef SW_DEBOUNCER_BYPASS_EN
    tbl = '{'{8'hA5, 8'h00, 1'b0}, '{8'hA5, 8'h00, 1'b0},
            '{8'hA5, 8'hA5, 1'b1}, '{8'hA5, 8'hA5, 1'b0},
            '{8'hA5, 8'hA5, 1'b0}, '{8'hA5, 8'hA5, 1'b0},
            '{8'hA5, 8'hA5, 1'b0}};
`else
    tbl = '{'{8'hA5, 8'h00, 1'b0}, '{8'hA5, 8'h00, 1'b0},
            '{8'hA5, 8'h00, 1'b0}, '{8'hA5, 8'h00, 1'b0},
            '{8'hA5, 8'h00, 1'b0}, '{8'hA5, 8'hA5, 1'b1},
            '{8'hA5, 8'hA5, 1'b0}};
`endif
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].sw, 1'b0);
      chk($sformatf("tbl%0d_sw", i), sw_o, tbl[i].exp_sw);
      chk($sformatf("tbl%0d_chg", i), {7'b0, changed_o},
          {7'b0, tbl[i].exp_chg});
    end

    for (int i = 0; i < 8; i++) step(8'h00, 1'b0);

    // Short glitch on bit 0 must be rejected.
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(8'h01, 1'b0);
      if (changed_o) pulses++;
    end
    for (int i = 0; i < 8; i++) begin
      step(8'h00, 1'b0);
      if (changed_o) pulses++;
    end
`ifndef SW_DEBOUNCER_BYPASS_EN
    chk("glitch_pulses", 8'(pulses), 8'd0);
`endif
    chk("glitch_word", sw_o, 8'h00);

    // Bit 3 bounces, then holds high.
    for (int i = 0; i < 10; i++) step((i % 2) ? 8'h08 : 8'h00, 1'b0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(8'h08, 1'b0);
      if (changed_o) pulses++;
    end
    chk("bounce_word", sw_o, 8'h08);
    chk("bounce_pulses", 8'(pulses), 8'd1);
    for (int i = 0; i < 8; i++) step(8'h00, 1'b0);

    // Bit 1 then bit 2 two edges later: two separate pulses.
    pulses = 0;
    step(8'h02, 1'b0);
    step(8'h02, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(8'h06, 1'b0);
      if (changed_o) pulses++;
    end
    chk("stagger_word", sw_o, 8'h06);
    chk("stagger_pulses", 8'(pulses), 8'd2);
    for (int i = 0; i < 8; i++) step(8'h00, 1'b0);

    // Reset mid-count, asserted between edges.
    for (int i = 0; i < 4; i++) step(8'h01, 1'b0);
    rst_i = 1'b1;
    #1;
    chk("async_rst_sw", sw_o, 8'h00);
    chk("async_rst_chg", {7'b0, changed_o}, 8'h00);
    model_reset();
    step(8'h01, 1'b1);
    step(8'h01, 1'b1);
    for (int i = 0; i < 7; i++) step(8'h01, 1'b0);
    chk("rst_mid_word", sw_o, 8'h01);

    // Random bouncing with occasional resets.
    cur = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
      step(cur, ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
